// File: rtl/axis_insert_arbiter.sv
// rtl/axis_insert_arbiter.sv - packet-level round-robin arbiter feeding one header inserter
// A grant covers one header beat plus one payload packet; both streams pass through combinationally.
module axis_insert_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int SRC_WD       = $clog2(NUM_SRC)
) (
    input  logic                              clk,
    input  logic                              rst_n,

    input  logic [NUM_SRC-1:0]                s_hdr_tvalid,
    input  logic [NUM_SRC*DATA_WD-1:0]        s_hdr_tdata,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_hdr_tkeep,
    output logic [NUM_SRC-1:0]                s_hdr_tready,

    input  logic [NUM_SRC-1:0]                s_pld_tvalid,
    input  logic [NUM_SRC*DATA_WD-1:0]        s_pld_tdata,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_pld_tkeep,
    input  logic [NUM_SRC-1:0]                s_pld_tlast,
    output logic [NUM_SRC-1:0]                s_pld_tready,

    output logic                              m00_axis_tvalid,
    output logic [DATA_WD-1:0]                m00_axis_tdata,
    output logic [DATA_BYTE_WD-1:0]           m00_axis_tkeep,
    input  logic                              m00_axis_tready,

    output logic                              m01_axis_tvalid,
    output logic [DATA_WD-1:0]                m01_axis_tdata,
    output logic [DATA_BYTE_WD-1:0]           m01_axis_tkeep,
    output logic                              m01_axis_tlast,
    input  logic                              m01_axis_tready,

    output logic                              grant_valid,
    output logic [SRC_WD-1:0]                 grant_id
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SRC_WD-1:0]   grant_id_q, grant_id_d;
    logic [SRC_WD-1:0]   last_id_q, last_id_d;
    logic                hdr_done_q, hdr_done_d;
    logic                pld_done_q, pld_done_d;

    logic                req_found;
    logic [SRC_WD-1:0]   req_idx;
    logic                hdr_hs;
    logic                pld_last_hs;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            last_id_q  <= SRC_WD'(NUM_SRC - 1);
            hdr_done_q <= 1'b0;
            pld_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            hdr_done_q <= hdr_done_d;
            pld_done_q <= pld_done_d;
        end
    end

    // Round-robin search starting just after the previously served source.
    always_comb begin
        int idx;
        req_found = 1'b0;
        req_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_id_q) + k) % NUM_SRC;
            if (!req_found && s_hdr_tvalid[idx]) begin
                req_found = 1'b1;
                req_idx   = SRC_WD'(idx);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        hdr_done_d = hdr_done_q;
        pld_done_d = pld_done_q;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    state_d    = XFER;
                    grant_id_d = req_idx;
                    hdr_done_d = 1'b0;
                    pld_done_d = 1'b0;
                end
            end
            XFER: begin
                hdr_done_d = hdr_done_q | hdr_hs;
                pld_done_d = pld_done_q | pld_last_hs;
                // Flags setting on this edge count, so a same-edge finish exits at once.
                if (hdr_done_d && pld_done_d) begin
                    state_d   = IDLE;
                    last_id_d = grant_id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: pass-through of the granted source, everything closed in IDLE.
    always_comb begin
        s_hdr_tready    = '0;
        s_pld_tready    = '0;
        m00_axis_tvalid = 1'b0;
        m00_axis_tdata  = '0;
        m00_axis_tkeep  = '0;
        m01_axis_tvalid = 1'b0;
        m01_axis_tdata  = '0;
        m01_axis_tkeep  = '0;
        m01_axis_tlast  = 1'b0;
        if (state_q == XFER) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_id_q == SRC_WD'(i)) begin
                    m00_axis_tvalid = s_hdr_tvalid[i] & ~hdr_done_q;
                    m00_axis_tdata  = s_hdr_tdata[i*DATA_WD +: DATA_WD];
                    m00_axis_tkeep  = s_hdr_tkeep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                    s_hdr_tready[i] = m00_axis_tready & ~hdr_done_q;
                    m01_axis_tvalid = s_pld_tvalid[i] & ~pld_done_q;
                    m01_axis_tdata  = s_pld_tdata[i*DATA_WD +: DATA_WD];
                    m01_axis_tkeep  = s_pld_tkeep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                    m01_axis_tlast  = s_pld_tlast[i];
                    s_pld_tready[i] = m01_axis_tready & ~pld_done_q;
                end
            end
        end
        hdr_hs      = m00_axis_tvalid & m00_axis_tready;
        pld_last_hs = m01_axis_tvalid & m01_axis_tready & m01_axis_tlast;
        grant_valid = (state_q == XFER);
        grant_id    = grant_id_q;
    end

endmodule

// File: tb/tb_axis_insert_arbiter.sv
// tb/tb_axis_insert_arbiter.sv - directed self-checking bench for axis_insert_arbiter
module tb_axis_insert_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int SW = 2;

    logic             clk;
    logic             rst_n;
    logic [NS-1:0]    s_hdr_tvalid;
    logic [NS*DW-1:0] s_hdr_tdata;
    logic [NS*KW-1:0] s_hdr_tkeep;
    logic [NS-1:0]    s_hdr_tready;
    logic [NS-1:0]    s_pld_tvalid;
    logic [NS*DW-1:0] s_pld_tdata;
    logic [NS*KW-1:0] s_pld_tkeep;
    logic [NS-1:0]    s_pld_tlast;
    logic [NS-1:0]    s_pld_tready;
    logic             m00_axis_tvalid;
    logic [DW-1:0]    m00_axis_tdata;
    logic [KW-1:0]    m00_axis_tkeep;
    logic             m00_axis_tready;
    logic             m01_axis_tvalid;
    logic [DW-1:0]    m01_axis_tdata;
    logic [KW-1:0]    m01_axis_tkeep;
    logic             m01_axis_tlast;
    logic             m01_axis_tready;
    logic             grant_valid;
    logic [SW-1:0]    grant_id;

    int vec_cnt;
    int err_cnt;

    axis_insert_arbiter #(.NUM_SRC(NS), .DATA_WD(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_hdr_tvalid(s_hdr_tvalid), .s_hdr_tdata(s_hdr_tdata), .s_hdr_tkeep(s_hdr_tkeep),
        .s_hdr_tready(s_hdr_tready),
        .s_pld_tvalid(s_pld_tvalid), .s_pld_tdata(s_pld_tdata), .s_pld_tkeep(s_pld_tkeep),
        .s_pld_tlast(s_pld_tlast), .s_pld_tready(s_pld_tready),
        .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tdata(m00_axis_tdata),
        .m00_axis_tkeep(m00_axis_tkeep), .m00_axis_tready(m00_axis_tready),
        .m01_axis_tvalid(m01_axis_tvalid), .m01_axis_tdata(m01_axis_tdata),
        .m01_axis_tkeep(m01_axis_tkeep), .m01_axis_tlast(m01_axis_tlast),
        .m01_axis_tready(m01_axis_tready),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, exp finish");
        $fatal(1);
    end

    task automatic clear_inputs;
        s_hdr_tvalid    = '0;
        s_hdr_tdata     = '0;
        s_hdr_tkeep     = '0;
        s_pld_tvalid    = '0;
        s_pld_tdata     = '0;
        s_pld_tkeep     = '0;
        s_pld_tlast     = '0;
        m00_axis_tready = 1'b1;
        m01_axis_tready = 1'b1;
    endtask

    // Leaves the bench at a falling edge with the DUT idle and freshly reset.
    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        s_hdr_tvalid = '1;
        s_pld_tvalid = '1;
        s_pld_tlast  = '1;
        @(negedge clk); #1;
        vec_cnt++; if (grant_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_grant_valid got=%0h exp=0", grant_valid); end
        vec_cnt++; if (grant_id !== 2'd0) begin err_cnt++; $display("FAIL rst_grant_id got=%0h exp=0", grant_id); end
        vec_cnt++; if (m00_axis_tvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_m00_tvalid got=%0h exp=0", m00_axis_tvalid); end
        vec_cnt++; if (m01_axis_tvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_m01_tvalid got=%0h exp=0", m01_axis_tvalid); end
        vec_cnt++; if (s_hdr_tready !== 4'b0000) begin err_cnt++; $display("FAIL rst_hdr_tready got=%0h exp=0", s_hdr_tready); end
        vec_cnt++; if (s_pld_tready !== 4'b0000) begin err_cnt++; $display("FAIL rst_pld_tready got=%0h exp=0", s_pld_tready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        vec_cnt++; if (grant_valid !== 1'b1) begin err_cnt++; $display("FAIL rst_rel_grant_valid got=%0h exp=1", grant_valid); end
        vec_cnt++; if (grant_id !== 2'd0) begin err_cnt++; $display("FAIL rst_rel_grant_id got=%0h exp=0", grant_id); end
    endtask

    task automatic test_single;
        do_reset();
        s_hdr_tvalid[2]      = 1'b1;
        s_hdr_tdata[64 +: 32] = 32'hA5A5A5A5;
        s_hdr_tkeep[8 +: 4]  = 4'b1111;
        s_pld_tvalid[2]      = 1'b1;
        s_pld_tdata[64 +: 32] = 32'h11111111;
        s_pld_tkeep[8 +: 4]  = 4'b1111;
        s_pld_tlast[2]       = 1'b0;
        #1;
        vec_cnt++; if (grant_valid !== 1'b0) begin err_cnt++; $display("FAIL single_idle_gv got=%0h exp=0", grant_valid); end
        vec_cnt++; if (s_hdr_tready !== 4'b0000) begin err_cnt++; $display("FAIL single_idle_hrdy got=%0h exp=0", s_hdr_tready); end
        @(negedge clk); #1;
        vec_cnt++; if (grant_valid !== 1'b1) begin err_cnt++; $display("FAIL single_gv got=%0h exp=1", grant_valid); end
        vec_cnt++; if (grant_id !== 2'd2) begin err_cnt++; $display("FAIL single_gid got=%0h exp=2", grant_id); end
        vec_cnt++; if (m00_axis_tvalid !== 1'b1) begin err_cnt++; $display("FAIL single_m00_valid got=%0h exp=1", m00_axis_tvalid); end
        vec_cnt++; if (m00_axis_tdata !== 32'hA5A5A5A5) begin err_cnt++; $display("FAIL single_m00_data got=%0h exp=a5a5a5a5", m00_axis_tdata); end
        vec_cnt++; if (m00_axis_tkeep !== 4'b1111) begin err_cnt++; $display("FAIL single_m00_keep got=%0h exp=f", m00_axis_tkeep); end
        vec_cnt++; if (s_hdr_tready !== 4'b0100) begin err_cnt++; $display("FAIL single_hrdy got=%0h exp=4", s_hdr_tready); end
        vec_cnt++; if (m01_axis_tdata !== 32'h11111111) begin err_cnt++; $display("FAIL single_beat1 got=%0h exp=11111111", m01_axis_tdata); end
        vec_cnt++; if (m01_axis_tlast !== 1'b0) begin err_cnt++; $display("FAIL single_beat1_last got=%0h exp=0", m01_axis_tlast); end
        vec_cnt++; if (s_pld_tready !== 4'b0100) begin err_cnt++; $display("FAIL single_prdy got=%0h exp=4", s_pld_tready); end
        @(negedge clk);
        s_hdr_tvalid[2]       = 1'b0;
        s_pld_tdata[64 +: 32] = 32'h22222222;
        #1;
        vec_cnt++; if (m00_axis_tvalid !== 1'b0) begin err_cnt++; $display("FAIL single_m00_done got=%0h exp=0", m00_axis_tvalid); end
        vec_cnt++; if (m01_axis_tdata !== 32'h22222222) begin err_cnt++; $display("FAIL single_beat2 got=%0h exp=22222222", m01_axis_tdata); end
        @(negedge clk);
        s_pld_tdata[64 +: 32] = 32'h33333333;
        s_pld_tlast[2]        = 1'b1;
        #1;
        vec_cnt++; if (m01_axis_tdata !== 32'h33333333) begin err_cnt++; $display("FAIL single_beat3 got=%0h exp=33333333", m01_axis_tdata); end
        vec_cnt++; if (m01_axis_tlast !== 1'b1) begin err_cnt++; $display("FAIL single_beat3_last got=%0h exp=1", m01_axis_tlast); end
        @(negedge clk);
        s_pld_tvalid[2] = 1'b0;
        s_pld_tlast[2]  = 1'b0;
        #1;
        vec_cnt++; if (grant_valid !== 1'b0) begin err_cnt++; $display("FAIL single_back_idle got=%0h exp=0", grant_valid); end
        // With last_id=2, sources 0 and 3 competing must resolve to 3.
        s_hdr_tvalid = 4'b1001;
        @(negedge clk); #1;
        vec_cnt++; if (grant_id !== 2'd3) begin err_cnt++; $display("FAIL single_last_id got=%0h exp=3", grant_id); end
    endtask

    task automatic test_fairness;
        logic [NS-1:0] cnt;
        int exp_order [6];
        int got;
        int prev_id;
        logic prev_gv;
        exp_order = '{0, 1, 2, 3, 0, 1};
        do_reset();
        cnt          = '0;
        got          = 0;
        prev_id      = -1;
        prev_gv      = 1'b0;
        s_hdr_tvalid = '1;
        s_pld_tvalid = '1;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            @(negedge clk);
            s_pld_tlast = cnt;
            #1;
            if (grant_valid && !prev_gv) begin
                vec_cnt++; if (int'(grant_id) !== exp_order[got]) begin err_cnt++; $display("FAIL fair_order%0d got=%0d exp=%0d", got, grant_id, exp_order[got]); end
                if (got > 0) begin
                    vec_cnt++; if (int'(grant_id) === prev_id) begin err_cnt++; $display("FAIL fair_repeat%0d got=%0d exp!=%0d", got, grant_id, prev_id); end
                end
                prev_id = int'(grant_id);
                got++;
            end
            prev_gv = grant_valid;
            for (int i = 0; i < NS; i++) begin
                if (s_pld_tready[i]) cnt[i] = ~cnt[i];
            end
        end
        vec_cnt++; if (got != 6) begin err_cnt++; $display("FAIL fair_timeout got=%0d exp=6 grants", got); end
    endtask

    task automatic test_backpressure;
        int b;
        int k;
        do_reset();
        s_hdr_tvalid[1]       = 1'b1;
        s_hdr_tdata[32 +: 32] = 32'h0BADBEEF;
        s_pld_tvalid[1]       = 1'b1;
        s_pld_tdata[32 +: 32] = 32'hB0000000;
        @(negedge clk);
        b = 0;
        k = 0;
        while (b < 4 && k < 20) begin
            m01_axis_tready       = (k % 2 == 0);
            s_pld_tdata[32 +: 32] = 32'hB0000000 + b;
            s_pld_tlast[1]        = (b == 3);
            if (k == 1) s_hdr_tvalid[1] = 1'b0;
            #1;
            vec_cnt++; if (m01_axis_tvalid !== 1'b1) begin err_cnt++; $display("FAIL bp_valid k%0d got=%0h exp=1", k, m01_axis_tvalid); end
            vec_cnt++; if (m01_axis_tdata !== 32'hB0000000 + b) begin err_cnt++; $display("FAIL bp_data k%0d got=%0h exp=%0h", k, m01_axis_tdata, 32'hB0000000 + b); end
            vec_cnt++; if (m01_axis_tlast !== (b == 3)) begin err_cnt++; $display("FAIL bp_last k%0d got=%0h exp=%0h", k, m01_axis_tlast, (b == 3)); end
            vec_cnt++; if (s_pld_tready !== {2'b00, m01_axis_tready, 1'b0}) begin err_cnt++; $display("FAIL bp_prdy k%0d got=%0h exp=%0h", k, s_pld_tready, {2'b00, m01_axis_tready, 1'b0}); end
            if (m01_axis_tready) b++;
            k++;
            @(negedge clk);
        end
        s_pld_tvalid[1] = 1'b0;
        s_pld_tlast[1]  = 1'b0;
        m01_axis_tready = 1'b1;
        #1;
        vec_cnt++; if (b != 4) begin err_cnt++; $display("FAIL bp_timeout got=%0d exp=4 beats", b); end
        vec_cnt++; if (grant_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_idle got=%0h exp=0", grant_valid); end
    endtask

    task automatic test_out_of_order;
        do_reset();
        m00_axis_tready      = 1'b0;
        s_hdr_tvalid[0]      = 1'b1;
        s_hdr_tdata[0 +: 32] = 32'hC0C0C0C0;
        s_pld_tvalid[0]      = 1'b1;
        s_pld_tdata[0 +: 32] = 32'hD0000001;
        @(negedge clk); #1;
        vec_cnt++; if (s_hdr_tready !== 4'b0000) begin err_cnt++; $display("FAIL ooo_hrdy_low got=%0h exp=0", s_hdr_tready); end
        vec_cnt++; if (m00_axis_tvalid !== 1'b1) begin err_cnt++; $display("FAIL ooo_m00_valid got=%0h exp=1", m00_axis_tvalid); end
        vec_cnt++; if (s_pld_tready !== 4'b0001) begin err_cnt++; $display("FAIL ooo_prdy got=%0h exp=1", s_pld_tready); end
        @(negedge clk);
        s_pld_tdata[0 +: 32] = 32'hD0000002;
        s_pld_tlast[0]       = 1'b1;
        #1;
        vec_cnt++; if (m01_axis_tlast !== 1'b1) begin err_cnt++; $display("FAIL ooo_last got=%0h exp=1", m01_axis_tlast); end
        @(negedge clk); #1;
        vec_cnt++; if (grant_valid !== 1'b1) begin err_cnt++; $display("FAIL ooo_hold got=%0h exp=1", grant_valid); end
        vec_cnt++; if (s_pld_tready !== 4'b0000) begin err_cnt++; $display("FAIL ooo_pld_closed got=%0h exp=0", s_pld_tready); end
        vec_cnt++; if (m01_axis_tvalid !== 1'b0) begin err_cnt++; $display("FAIL ooo_m01_closed got=%0h exp=0", m01_axis_tvalid); end
        @(negedge clk);
        m00_axis_tready = 1'b1;
        #1;
        vec_cnt++; if (grant_valid !== 1'b1) begin err_cnt++; $display("FAIL ooo_hold2 got=%0h exp=1", grant_valid); end
        vec_cnt++; if (s_hdr_tready !== 4'b0001) begin err_cnt++; $display("FAIL ooo_hrdy got=%0h exp=1", s_hdr_tready); end
        vec_cnt++; if (m00_axis_tdata !== 32'hC0C0C0C0) begin err_cnt++; $display("FAIL ooo_hdr_data got=%0h exp=c0c0c0c0", m00_axis_tdata); end
        @(negedge clk);
        s_hdr_tvalid = '0;
        s_pld_tvalid = '0;
        s_pld_tlast  = '0;
        #1;
        vec_cnt++; if (grant_valid !== 1'b0) begin err_cnt++; $display("FAIL ooo_idle got=%0h exp=0", grant_valid); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        s_hdr_tvalid[3]       = 1'b1;
        s_pld_tvalid[3]       = 1'b1;
        s_pld_tdata[96 +: 32] = 32'hE0000001;
        @(negedge clk); #1;
        vec_cnt++; if (grant_id !== 2'd3) begin err_cnt++; $display("FAIL mid_gid got=%0h exp=3", grant_id); end
        @(negedge clk);
        s_hdr_tvalid[3]       = 1'b0;
        s_pld_tdata[96 +: 32] = 32'hE0000002;
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (grant_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_gv got=%0h exp=0", grant_valid); end
        vec_cnt++; if (grant_id !== 2'd0) begin err_cnt++; $display("FAIL mid_gid_rst got=%0h exp=0", grant_id); end
        vec_cnt++; if (m01_axis_tvalid !== 1'b0) begin err_cnt++; $display("FAIL mid_m01 got=%0h exp=0", m01_axis_tvalid); end
        vec_cnt++; if (s_pld_tready !== 4'b0000) begin err_cnt++; $display("FAIL mid_prdy got=%0h exp=0", s_pld_tready); end
        s_hdr_tvalid = 4'b1010;
        s_pld_tvalid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        vec_cnt++; if (grant_valid !== 1'b1) begin err_cnt++; $display("FAIL mid_regrant_gv got=%0h exp=1", grant_valid); end
        vec_cnt++; if (grant_id !== 2'd1) begin err_cnt++; $display("FAIL mid_regrant_gid got=%0h exp=1", grant_id); end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n   = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_out_of_order();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
